// File: rtl/ia_tile_scheduler.sv
// Input-activation tile scheduler: walks col/row/reduction tile indices for one
// matmul job, arbitrating loader memory grants and triggering tile sends.
module ia_tile_scheduler #(
    parameter int SIZE      = 16,
    parameter int REG_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [REG_WIDTH-1:0] k,
    input  logic [REG_WIDTH-1:0] n,
    input  logic [REG_WIDTH-1:0] m,
    input  logic                 mem_busy,
    input  logic                 array_ready,
    input  logic                 load_ia_req,
    input  logic                 ia_data_valid,
    input  logic                 ia_sending_done,
    output logic                 init_cfg,
    output logic                 load_ia_granted,
    output logic                 send_ia_trigger,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [REG_WIDTH-1:0] row_blk,
    output logic [REG_WIDTH-1:0] red_blk,
    output logic [REG_WIDTH-1:0] col_blk
);

    localparam int SHIFT = $clog2(SIZE);
    localparam logic [REG_WIDTH:0]   ROUND_UP = (REG_WIDTH + 1)'(SIZE - 1);
    localparam logic [REG_WIDTH-1:0] ZERO     = {REG_WIDTH{1'b0}};
    localparam logic [REG_WIDTH-1:0] ONE      = {{(REG_WIDTH - 1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CFG       = 3'd1,
        ST_LOAD      = 3'd2,
        ST_WAIT_ARR  = 3'd3,
        ST_SEND      = 3'd4,
        ST_WAIT_DONE = 3'd5,
        ST_DONE      = 3'd6
    } state_t;

    // One extra bit of headroom keeps x close to 2^REG_WIDTH from wrapping.
    function automatic logic [REG_WIDTH-1:0] tile_count(input logic [REG_WIDTH-1:0] x);
        logic [REG_WIDTH:0] sum;
        logic [REG_WIDTH:0] quo;
        sum = {1'b0, x} + ROUND_UP;
        quo = sum >> SHIFT;
        return quo[REG_WIDTH-1:0];
    endfunction

    state_t               state_r, state_nxt_s;
    logic [REG_WIDTH-1:0] rb_r, nb_r, mb_r;
    logic [REG_WIDTH-1:0] row_r, red_r, col_r;
    logic                 init_r, grant_r, trig_r, busy_r, done_r, err_r;
    logic                 init_nxt_s, grant_nxt_s, trig_nxt_s, busy_nxt_s, done_nxt_s, err_nxt_s;
    logic                 accept_s, zero_dim_s, advance_s, last_tile_s;

    assign accept_s    = (state_r == ST_IDLE) && start;
    assign zero_dim_s  = (rb_r == ZERO) || (nb_r == ZERO) || (mb_r == ZERO);
    assign advance_s   = (state_r == ST_WAIT_DONE) && ia_sending_done;
    assign last_tile_s = (red_r == nb_r - ONE) && (row_r == rb_r - ONE) && (col_r == mb_r - ONE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:      if (start) state_nxt_s = ST_CFG; else state_nxt_s = ST_IDLE;
            ST_CFG:       if (zero_dim_s) state_nxt_s = ST_DONE; else state_nxt_s = ST_LOAD;
            ST_LOAD:      if (ia_data_valid) state_nxt_s = ST_WAIT_ARR; else state_nxt_s = ST_LOAD;
            ST_WAIT_ARR:  if (array_ready) state_nxt_s = ST_SEND; else state_nxt_s = ST_WAIT_ARR;
            ST_SEND:      state_nxt_s = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (ia_sending_done) begin
                    if (last_tile_s) state_nxt_s = ST_DONE;
                    else             state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_WAIT_DONE;
                end
            end
            ST_DONE:      state_nxt_s = ST_IDLE;
            default:      state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode; values land in registers so every pulse trails its cause by one cycle.
    always_comb begin
        init_nxt_s  = (state_nxt_s == ST_CFG);
        grant_nxt_s = (state_r == ST_LOAD) && load_ia_req && !mem_busy && !ia_data_valid;
        trig_nxt_s  = (state_nxt_s == ST_SEND);
        done_nxt_s  = (state_nxt_s == ST_DONE);
        busy_nxt_s  = (state_nxt_s != ST_IDLE);
        if (accept_s) begin
            err_nxt_s = 1'b0;
        end else if ((state_r == ST_CFG) && zero_dim_s) begin
            err_nxt_s = 1'b1;
        end else begin
            err_nxt_s = err_r;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            init_r  <= 1'b0;
            grant_r <= 1'b0;
            trig_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            init_r  <= init_nxt_s;
            grant_r <= grant_nxt_s;
            trig_r  <= trig_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
            err_r   <= err_nxt_s;
        end
    end

    // Tile counts and indices; indices hold after the final tile so the last position stays visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            rb_r  <= ZERO;
            nb_r  <= ZERO;
            mb_r  <= ZERO;
            row_r <= ZERO;
            red_r <= ZERO;
            col_r <= ZERO;
        end else if (accept_s) begin
            rb_r  <= tile_count(k);
            nb_r  <= tile_count(n);
            mb_r  <= tile_count(m);
            row_r <= ZERO;
            red_r <= ZERO;
            col_r <= ZERO;
        end else if (advance_s && !last_tile_s) begin
            if (red_r != nb_r - ONE) begin
                red_r <= red_r + ONE;
            end else begin
                red_r <= ZERO;
                if (row_r != rb_r - ONE) begin
                    row_r <= row_r + ONE;
                end else begin
                    row_r <= ZERO;
                    col_r <= col_r + ONE;
                end
            end
        end
    end

    assign init_cfg        = init_r;
    assign load_ia_granted = grant_r;
    assign send_ia_trigger = trig_r;
    assign busy            = busy_r;
    assign done            = done_r;
    assign err             = err_r;
    assign row_blk         = row_r;
    assign red_blk         = red_r;
    assign col_blk         = col_r;

endmodule

// File: tb/tb_ia_tile_scheduler.sv
// Directed bench for ia_tile_scheduler: a table of whole jobs driven through a
// simple loader model, plus hand sequences for stalls, reset and ignored starts.
module tb_ia_tile_scheduler;

    logic        clk = 1'b0;
    logic        rst, start, mem_busy, array_ready, load_ia_req, ia_data_valid, ia_sending_done;
    logic [31:0] k, n, m;
    logic        init_cfg, load_ia_granted, send_ia_trigger, busy, done, err;
    logic [31:0] row_blk, red_blk, col_blk;

    ia_tile_scheduler #(.SIZE(16), .REG_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .k(k), .n(n), .m(m),
        .mem_busy(mem_busy), .array_ready(array_ready), .load_ia_req(load_ia_req),
        .ia_data_valid(ia_data_valid), .ia_sending_done(ia_sending_done),
        .init_cfg(init_cfg), .load_ia_granted(load_ia_granted), .send_ia_trigger(send_ia_trigger),
        .busy(busy), .done(done), .err(err),
        .row_blk(row_blk), .red_blk(red_blk), .col_blk(col_blk)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] k, n, m;
        int          tiles;
        logic        err;
        logic [31:0] lcol, lrow, lred;
    } vec_t;

    vec_t vecs[5];
    int   checks = 0;
    int   errors = 0;
    int   n_trig, n_grant, n_init, n_done, n_excl, cd, exp_n;
    logic err_at_done;
    int   exp_col[64], exp_row[64], exp_red[64];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        n_trig = 0; n_grant = 0; n_init = 0; n_done = 0; n_excl = 0; cd = 0;
        err_at_done = 1'b0;
        ia_data_valid = 1'b0;
        ia_sending_done = 1'b0;
    endtask

    // Expected tile order: col outermost, then row, then reduction.
    task automatic build_expect(input longint kk, input longint nn, input longint mm);
        longint rb, nb, mb;
        rb = (kk + 15) / 16; nb = (nn + 15) / 16; mb = (mm + 15) / 16;
        exp_n = 0;
        for (longint c = 0; c < mb; c++)
            for (longint r = 0; r < rb; r++)
                for (longint d = 0; d < nb; d++) begin
                    if (exp_n < 64) begin
                        exp_col[exp_n] = int'(c); exp_row[exp_n] = int'(r); exp_red[exp_n] = int'(d);
                    end
                    exp_n++;
                end
    endtask

    task automatic start_job(input logic [31:0] kk, input logic [31:0] nn, input logic [31:0] mm);
        k = kk; n = nn; m = mm; start = 1'b1;
        step();
        start = 1'b0;
        check("init_after_start", init_cfg, 1);
        check("busy_after_start", busy, 1);
        check("err_cleared_on_start", err, 0);
    endtask

    // Loader model: data becomes valid after a grant, sending_done pulses in WAIT_DONE.
    task automatic run_loader(input int budget, input int stop_trig, input int extra_start_at);
        bit fin = 1'b0;
        bit got_done = 1'b0;
        for (int cyc = 0; cyc < budget && !fin; cyc++) begin
            step();
            if (int'(init_cfg) + int'(load_ia_granted) + int'(send_ia_trigger) > 1) n_excl++;
            if (got_done) begin
                check("busy_low_after_done", busy, 0);
                check("done_one_cycle", done, 0);
                fin = 1'b1;
            end else begin
                if (init_cfg) n_init++;
                if (load_ia_granted) begin
                    n_grant++;
                    ia_data_valid = 1'b1;
                end
                if (send_ia_trigger) begin
                    if (n_trig < exp_n && n_trig < 64) begin
                        check("trig_col_blk", col_blk, exp_col[n_trig]);
                        check("trig_row_blk", row_blk, exp_row[n_trig]);
                        check("trig_red_blk", red_blk, exp_red[n_trig]);
                    end
                    n_trig++;
                    ia_data_valid = 1'b0;
                    cd = 2;
                    if (n_trig == stop_trig) fin = 1'b1;
                end
                if (done) begin
                    n_done++;
                    err_at_done = err;
                    got_done = 1'b1;
                end
            end
            ia_sending_done = (cd == 1);
            if (cd > 0) cd--;
            start = (cyc == extra_start_at);
        end
        start = 1'b0;
        check("loader_within_budget", fin, 1);
    endtask

    initial begin
        bit found;
        int seen;

        vecs[0] = '{k:32'd32, n:32'd48, m:32'd16, tiles:6, err:1'b0, lcol:32'd0, lrow:32'd1, lred:32'd2};
        vecs[1] = '{k:32'd17, n:32'd1,  m:32'd33, tiles:6, err:1'b0, lcol:32'd2, lrow:32'd1, lred:32'd0};
        vecs[2] = '{k:32'd40, n:32'd0,  m:32'd16, tiles:0, err:1'b1, lcol:32'd0, lrow:32'd0, lred:32'd0};
        vecs[3] = '{k:32'd16, n:32'd16, m:32'd16, tiles:1, err:1'b0, lcol:32'd0, lrow:32'd0, lred:32'd0};
        vecs[4] = '{k:32'd1,  n:32'd17, m:32'd1,  tiles:2, err:1'b0, lcol:32'd0, lrow:32'd0, lred:32'd1};

        rst = 1'b1; start = 1'b0; mem_busy = 1'b0; array_ready = 1'b1; load_ia_req = 1'b1;
        k = 32'd0; n = 32'd0; m = 32'd0;
        clear_counts();
        repeat (3) step();
        check("reset_outputs", {init_cfg, load_ia_granted, send_ia_trigger, busy, done, err}, 0);
        check("reset_indices", row_blk | red_blk | col_blk, 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 5; i++) begin
            clear_counts();
            build_expect(vecs[i].k, vecs[i].n, vecs[i].m);
            start_job(vecs[i].k, vecs[i].n, vecs[i].m);
            run_loader(2000, -1, -1);
            check("job_triggers", n_trig, vecs[i].tiles);
            check("job_grants", n_grant, vecs[i].tiles);
            check("job_extra_init", n_init, 0);
            check("job_done_count", n_done, 1);
            check("job_err_with_done", err_at_done, vecs[i].err);
            check("job_last_col", col_blk, vecs[i].lcol);
            check("job_last_row", row_blk, vecs[i].lrow);
            check("job_last_red", red_blk, vecs[i].lred);
            check("job_pulse_exclusive", n_excl, 0);
            step();
        end

        // mem_busy blocks grants; grant one cycle after it drops.
        clear_counts();
        build_expect(16, 16, 16);
        mem_busy = 1'b1;
        start_job(32'd16, 32'd16, 32'd16);
        seen = 0;
        repeat (11) begin
            step();
            if (load_ia_granted) seen++;
        end
        check("no_grant_while_mem_busy", seen, 0);
        mem_busy = 1'b0;
        step();
        check("grant_after_mem_busy", load_ia_granted, 1);
        n_grant = 1;
        ia_data_valid = 1'b1;
        run_loader(200, -1, -1);
        check("membusy_job_triggers", n_trig, 1);
        check("membusy_job_done", n_done, 1);
        step();

        // array_ready low holds off the trigger.
        clear_counts();
        build_expect(16, 16, 16);
        array_ready = 1'b0;
        start_job(32'd16, 32'd16, 32'd16);
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            step();
            if (load_ia_granted) found = 1'b1;
        end
        check("grant_seen_before_ready_test", found, 1);
        ia_data_valid = 1'b1;
        step();
        seen = 0;
        repeat (8) begin
            step();
            if (send_ia_trigger) seen++;
        end
        check("no_trigger_while_not_ready", seen, 0);
        array_ready = 1'b1;
        step();
        check("trigger_after_ready", send_ia_trigger, 1);
        n_trig = 1;
        ia_data_valid = 1'b0;
        cd = 2;
        run_loader(200, -1, -1);
        check("ready_job_done", n_done, 1);
        check("ready_job_triggers", n_trig, 1);
        step();

        // Reset in WAIT_DONE of tile 3 aborts the job.
        clear_counts();
        build_expect(32, 48, 16);
        start_job(32'd32, 32'd48, 32'd16);
        run_loader(500, 3, -1);
        ia_sending_done = 1'b0; ia_data_valid = 1'b0; cd = 0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_outputs_zero", {init_cfg, load_ia_granted, send_ia_trigger, busy, done, err}, 0);
        check("abort_indices_zero", row_blk | red_blk | col_blk, 0);
        seen = 0;
        repeat (4) begin
            step();
            if (busy || done) seen++;
        end
        check("idle_after_abort", seen, 0);

        // Clean job afterwards with a stray start while busy.
        clear_counts();
        build_expect(32, 48, 16);
        start_job(32'd32, 32'd48, 32'd16);
        run_loader(2000, -1, 5);
        check("clean_job_triggers", n_trig, 6);
        check("clean_job_done", n_done, 1);
        check("clean_job_extra_init", n_init, 0);
        check("clean_job_err", err_at_done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
